alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter OP_MAX, default 8'd12, giving the highest defined ALU opcode.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port ena, input, 1: when low, state is frozen and in_ready is forced to 0.
REQ-005 The block SHALL have port in_data, input, 8: byte stream carrying first the operand byte {y[3:0],x[3:0]}, then the opcode byte.
REQ-006 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream valid/ready handshake.
REQ-007 The block SHALL have port alu_operands, output, 8, registered operand byte driven to the downstream ALU ui_in.
REQ-008 The block SHALL have port alu_opcode, output, 8, registered opcode driven to the downstream ALU uio_in.
REQ-009 The block SHALL have port alu_result, input, 8, the combinational ALU result.
REQ-010 The block SHALL have ports out_data (output, 8), out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-011 The block SHALL have port err, output, 1, a divide-by-zero flag qualified by out_valid.
REQ-012 The block SHALL have port op_count, output, 8, a count of completed result handshakes.

Function
REQ-013 The block SHALL implement FSM states IDLE, GET_OP, EXEC and DONE.
REQ-014 IDLE SHALL behave as follows: in_ready=1; on in_valid&in_ready, load alu_operands<=in_data and go to GET_OP.
REQ-015 GET_OP SHALL behave as follows: in_ready=1; on handshake, load alu_opcode<=in_data and go to EXEC.
REQ-016 EXEC SHALL last exactly one cycle with in_ready=0, then capture the result and go to DONE; out_valid SHALL rise after the first rising edge following the opcode handshake edge.
REQ-017 Result capture SHALL set err=1 and out_data=8'hFF when alu_opcode is 3 or 10 and alu_operands[7:4]==0; otherwise it SHALL set out_data=alu_result and err=0.
REQ-018 Opcodes above OP_MAX SHALL be forwarded unchanged; out_data then equals the ALU result (pass-through of operands) and err=0.
REQ-019 DONE SHALL hold out_valid=1, out_data and err stable and in_ready=0 until out_valid&out_ready, then go to IDLE with out_valid=0 and err=0.
REQ-020 On every DONE handshake, op_count SHALL increment by 1, wrapping 8'hFF->8'h00.
REQ-021 alu_operands and alu_opcode SHALL retain their last loaded values in IDLE and DONE.
REQ-022 With ena low, no state, register or counter SHALL change, and in_valid and out_ready SHALL be ignored; out_valid and out_data SHALL hold.
REQ-023 Peak throughput SHALL be one operation per 4 cycles; no overlap between DONE and IDLE acceptance.

Reset
REQ-024 While rst_n=0, the block SHALL be in state IDLE with alu_operands=0, alu_opcode=0, out_data=0, out_valid=0, err=0 and op_count=0; in_ready SHALL be 1 once rst_n=1 and ena=1.
REQ-025 Reset asserted in any state, including mid-EXEC or DONE, SHALL abandon the operation without incrementing op_count.

Structure
REQ-026 The shared package SHALL hold opcode constants OP_ADD=0 through OP_SHR=12, OP_DIV=3, OP_MOD=10, and the FSM state enum.
REQ-027 The ALU SHALL remain a sibling instantiated by the top level; no sub-module is required inside this block.

Verification
REQ-028 The bench SHALL send operand 0x53 then opcode 0x00: the ALU sees ui_in=0x53; out_data=0x08, err=0, op_count=1.
REQ-029 The bench SHALL send operand 0x53 then opcode 0x01: out_data=0xFE (3-5); opcode 0x02 SHALL give 0x0F.
REQ-030 The bench SHALL send operand 0x07 then opcode 0x03: out_data=0xFF, err=1; with opcode 0x0A the response SHALL be the same.
REQ-031 The bench SHALL hold out_ready low for 5 cycles in DONE: out_data and out_valid SHALL stay stable, in_ready=0, in_valid pulses SHALL be ignored, and op_count SHALL increment only at release.
REQ-032 The bench SHALL drop ena for 3 cycles during GET_OP, then pulse rst_n low during EXEC: the FSM SHALL freeze, then return to IDLE with all outputs at reset values.
REQ-033 The bench SHALL complete 256 operations: op_count SHALL wrap to 0x00.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and helpers for the ALU operation sequencer.
package alu_op_sequencer_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_SUB = 8'd1;
  localparam logic [7:0] OP_MUL = 8'd2;
  localparam logic [7:0] OP_DIV = 8'd3;
  localparam logic [7:0] OP_AND = 8'd4;
  localparam logic [7:0] OP_OR  = 8'd5;
  localparam logic [7:0] OP_XOR = 8'd6;
  localparam logic [7:0] OP_NOT = 8'd7;
  localparam logic [7:0] OP_SHL = 8'd8;
  localparam logic [7:0] OP_LT  = 8'd9;
  localparam logic [7:0] OP_MOD = 8'd10;
  localparam logic [7:0] OP_EQ  = 8'd11;
  localparam logic [7:0] OP_SHR = 8'd12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_OP = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Opcodes whose divisor is operand y.
  function automatic logic is_div_op(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences an operand byte and an opcode byte into a sibling ALU, captures its
// result with divide-by-zero trapping, and hands it downstream.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter logic [7:0] OP_MAX = 8'd12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_operands,
  output logic [DATA_W-1:0] alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err,
  output logic [DATA_W-1:0] op_count
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] operands_q, operands_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] op_count_q, op_count_d;
  logic              div_zero_c;

  // Upstream may only push in the two loading states, and never while frozen.
  assign in_ready = ena && ((state_q == IDLE) || (state_q == GET_OP));

  assign div_zero_c = (opcode_q <= OP_MAX) && is_div_op(opcode_q)
                      && (operands_q[7:4] == 4'd0);

  always_comb begin
    state_d     = state_q;
    operands_d  = operands_q;
    opcode_d    = opcode_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    op_count_d  = op_count_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            operands_d = in_data;
            state_d    = GET_OP;
          end
        end
        GET_OP: begin
          if (in_valid && in_ready) begin
            opcode_d = in_data;
            state_d  = EXEC;
          end
        end
        EXEC: begin
          out_valid_d = 1'b1;
          if (div_zero_c) begin
            out_data_d = 8'hFF;
            err_d      = 1'b1;
          end else begin
            out_data_d = alu_result;
            err_d      = 1'b0;
          end
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            err_d       = 1'b0;
            op_count_d  = op_count_q + 8'd1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      operands_q  <= '0;
      opcode_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      operands_q  <= operands_d;
      opcode_q    <= opcode_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_operands = operands_q;
  assign alu_opcode   = opcode_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign err          = err_q;
  assign op_count     = op_count_q;

endmodule
